// File: rtl/pipeline_dest_tracker.sv
// pipeline_dest_tracker: EX/MEM/WB destination-register, write-enable and load-flag tracking for hazard/forwarding
// Ports: clk, rst (async, active-high); ID_RD/ID_RF_E/ID_load_instr describe the instruction in ID;
// CUMUX_E/flush insert a bubble into EX; hold freezes every entry; RD_*/*_RF_E/EX_load are direct register outputs.
// Optional DEST_TRACK_STATS_EN adds parameter CNT_W and saturating stall_cnt/flush_cnt ports.
module pipeline_dest_tracker #(
  parameter int REG_W = 5
`ifdef DEST_TRACK_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_RD,
  input  logic             ID_RF_E,
  input  logic             ID_load_instr,
  input  logic             CUMUX_E,
  input  logic             flush,
  input  logic             hold,
  output logic [REG_W-1:0] RD_EX,
  output logic [REG_W-1:0] RD_MEM,
  output logic [REG_W-1:0] RD_WB,
  output logic             EX_RF_E,
  output logic             MEM_RF_E,
  output logic             WB_RF_E,
`ifdef DEST_TRACK_STATS_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             EX_load
);
  logic bubble;
  logic load_mem;
  logic load_wb_unused;
  assign bubble = CUMUX_E | flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      RD_EX          <= '0;
      RD_MEM         <= '0;
      RD_WB          <= '0;
      EX_RF_E        <= 1'b0;
      MEM_RF_E       <= 1'b0;
      WB_RF_E        <= 1'b0;
      EX_load        <= 1'b0;
      load_mem       <= 1'b0;
      load_wb_unused <= 1'b0;
    end else if (!hold) begin
      RD_WB          <= RD_MEM;
      WB_RF_E        <= MEM_RF_E;
      load_wb_unused <= load_mem;
      RD_MEM         <= RD_EX;
      MEM_RF_E       <= EX_RF_E;
      load_mem       <= EX_load;
      RD_EX          <= bubble ? '0 : ID_RD;
      // x0 never reports a write, so downstream compares cannot match it
      EX_RF_E        <= !bubble && ID_RF_E && (|ID_RD);
      EX_load        <= !bubble && ID_load_instr;
    end
`ifdef DEST_TRACK_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      if (CUMUX_E && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipeline_dest_tracker.sv
// tb_pipeline_dest_tracker: directed self-checking bench for pipeline_dest_tracker
module tb_pipeline_dest_tracker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rd = '0;
  logic       id_rf_e = 1'b0;
  logic       id_load = 1'b0;
  logic       cumux_e = 1'b0;
  logic       flush = 1'b0;
  logic       hold = 1'b0;
  logic [4:0] rd_ex, rd_mem, rd_wb;
  logic       ex_rf_e, mem_rf_e, wb_rf_e, ex_load;
  logic [18:0] outs;
  int checks = 0;
  int errors = 0;
`ifdef DEST_TRACK_STATS_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif
  pipeline_dest_tracker #(
    .REG_W(5)
`ifdef DEST_TRACK_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .ID_RD(id_rd),
    .ID_RF_E(id_rf_e),
    .ID_load_instr(id_load),
    .CUMUX_E(cumux_e),
    .flush(flush),
    .hold(hold),
    .RD_EX(rd_ex),
    .RD_MEM(rd_mem),
    .RD_WB(rd_wb),
    .EX_RF_E(ex_rf_e),
    .MEM_RF_E(mem_rf_e),
    .WB_RF_E(wb_rf_e),
`ifdef DEST_TRACK_STATS_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .EX_load(ex_load)
  );
  always #5 clk = ~clk;
  assign outs = {rd_ex, rd_mem, rd_wb, ex_rf_e, mem_rf_e, wb_rf_e, ex_load};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rd, input logic rf, input logic ld);
    id_rd = rd;
    id_rf_e = rf;
    id_load = ld;
  endtask
  initial begin
    issue(5'd17, 1'b1, 1'b1);
    cumux_e = 1'b1;
    #1 chk("reset_t0", 32'(outs), 32'd0);
    step;
    issue(5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    cumux_e = 1'b0;
    step;
    chk("reset_toggle", 32'(outs), 32'd0);
    issue(5'd0, 1'b0, 1'b0);
    flush = 1'b0;
    rst = 1'b0;
    step;
    chk("reset_release", 32'(outs), 32'd0);
    issue(5'd5, 1'b1, 1'b0);
    step;
    chk("c1_ex", 32'({rd_ex, ex_rf_e}), 32'({5'd5, 1'b1}));
    issue(5'd7, 1'b1, 1'b0);
    step;
    chk("c2_mem_ex", 32'({rd_mem, rd_ex}), 32'({5'd5, 5'd7}));
    issue(5'd0, 1'b1, 1'b0);
    step;
    chk("c3_all", 32'(outs), 32'({5'd0, 5'd7, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0}));
    issue(5'd3, 1'b1, 1'b1);
    step;
    chk("load_ex", 32'({rd_ex, ex_rf_e, ex_load}), 32'({5'd3, 1'b1, 1'b1}));
    issue(5'd4, 1'b1, 1'b0);
    cumux_e = 1'b1;
    step;
    chk("load_bubble", 32'({rd_mem, mem_rf_e, rd_ex, ex_rf_e, ex_load}), 32'({5'd3, 1'b1, 5'd0, 1'b0, 1'b0}));
    cumux_e = 1'b0;
    step;
    chk("stall_release", 32'({rd_ex, ex_rf_e, rd_wb}), 32'({5'd4, 1'b1, 5'd3}));
    issue(5'd12, 1'b1, 1'b1);
    flush = 1'b1;
    step;
    chk("flush_bubble", 32'({rd_ex, ex_rf_e, ex_load, rd_mem}), 32'({5'd0, 1'b0, 1'b0, 5'd4}));
    flush = 1'b0;
    issue(5'd3, 1'b1, 1'b0);
    step;
    issue(5'd2, 1'b1, 1'b0);
    step;
    issue(5'd1, 1'b1, 1'b0);
    step;
    chk("hold_setup", 32'(outs), 32'({5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0}));
`ifdef DEST_TRACK_STATS_EN
    chk("hold_pre_stall", 32'(stall_cnt), 32'd1);
    chk("hold_pre_flush", 32'(flush_cnt), 32'd1);
`endif
    issue(5'd9, 1'b1, 1'b1);
    hold = 1'b1;
    flush = 1'b1;
    cumux_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("hold_%0d", i), 32'(outs), 32'({5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0}));
`ifdef DEST_TRACK_STATS_EN
      chk($sformatf("hold_cnt_%0d", i), 32'({stall_cnt, flush_cnt}), 32'({4'd1, 4'd1}));
`endif
    end
    hold = 1'b0;
    flush = 1'b0;
    cumux_e = 1'b0;
    issue(5'd6, 1'b1, 1'b0);
    step;
    chk("hold_resume", 32'(outs), 32'({5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0}));
    #2 rst = 1'b1;
    #1 chk("async_reset", 32'(outs), 32'd0);
`ifdef DEST_TRACK_STATS_EN
    chk("async_reset_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
`endif
    step;
    rst = 1'b0;
    issue(5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    cumux_e = 1'b1;
    step;
    chk("both_bubble", 32'({rd_ex, ex_rf_e}), 32'd0);
`ifdef DEST_TRACK_STATS_EN
    chk("both_cnt", 32'({stall_cnt, flush_cnt}), 32'({4'd1, 4'd1}));
`endif
    flush = 1'b0;
    for (int i = 0; i < 20; i++) step;
    chk("stall_bubbles", 32'(outs), 32'd0);
`ifdef DEST_TRACK_STATS_EN
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    chk("flush_hold_cnt", 32'(flush_cnt), 32'd1);
`endif
    cumux_e = 1'b0;
    issue(5'd0, 1'b1, 1'b1);
    step;
    chk("x0_filter", 32'({rd_ex, ex_rf_e, ex_load}), 32'({5'd0, 1'b0, 1'b1}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
